// File: rtl/find_bw_pkg.sv
// Shared types for the two-sided bandwidth edge finder: FSM states,
// per-edge bracket record and the Q8.8 fixed-point constant.
package find_bw_pkg;

  localparam int unsigned Q_FRAC_BITS = 8;
  localparam int unsigned FB_FREQ_W   = 16;
  localparam int unsigned FB_ACC_W    = 18;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PEAK  = 3'd1,
    ST_LEFT  = 3'd2,
    ST_RIGHT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic [FB_FREQ_W-1:0] f1;
    logic [FB_FREQ_W-1:0] f2;
    logic [FB_ACC_W-1:0]  l1;
    logic [FB_ACC_W-1:0]  l2;
    logic                 found;
  } edge_result_t;

endpackage

// File: rtl/find_bw_peak_search.sv
// Sequential argmax over a registered snapshot, one bin per cycle from index 0;
// strict compare keeps the first occurrence of a tied maximum.
module find_bw_peak_search #(
  parameter int unsigned ACCUM_WIDTH = 18,
  parameter int unsigned NUM_ACCUMS  = 24
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [ACCUM_WIDTH-1:0]        vals_i [NUM_ACCUMS],
  output logic [$clog2(NUM_ACCUMS)-1:0] peak_idx_o,
  output logic [ACCUM_WIDTH-1:0]        peak_val_o,
  output logic                          done_c
);

  localparam int unsigned IW = $clog2(NUM_ACCUMS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ACCUMS - 1);

  logic                   active_q, active_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [IW-1:0]          pidx_q, pidx_d;
  logic [ACCUM_WIDTH-1:0] pval_q, pval_d;

  always_comb begin
    active_d = active_q;
    idx_d    = idx_q;
    pidx_d   = pidx_q;
    pval_d   = pval_q;
    done_c   = active_q && (idx_q == LAST_IDX);
    if (start_i) begin
      active_d = 1'b1;
      idx_d    = '0;
    end else if (active_q) begin
      // Bin 0 seeds the running maximum unconditionally.
      if ((idx_q == '0) || ($signed(vals_i[idx_q]) > $signed(pval_q))) begin
        pidx_d = idx_q;
        pval_d = vals_i[idx_q];
      end
      if (done_c) active_d = 1'b0;
      else        idx_d    = idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      idx_q    <= '0;
      pidx_q   <= '0;
      pval_q   <= '0;
    end else begin
      active_q <= active_d;
      idx_q    <= idx_d;
      pidx_q   <= pidx_d;
      pval_q   <= pval_d;
    end
  end

  assign peak_idx_o = pidx_q;
  assign peak_val_o = pval_q;

endmodule

// File: rtl/find_bw_edges.sv
// Finds the peak of a spectrum snapshot and the bracketing bins of the left and
// right (peak - threshold) crossings. FIND_BW_BANDWIDTH_EN adds the bw_o output.
module find_bw_edges
  import find_bw_pkg::*;
#(
  parameter int unsigned ACCUM_WIDTH    = 18,
  parameter int unsigned FREQ_BIN_WIDTH = 16,
  parameter int unsigned NUM_ACCUMS     = 24,
  parameter int unsigned THRESH_WIDTH   = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   start_i,
  input  logic [NUM_ACCUMS*ACCUM_WIDTH-1:0]      accumulator_val_i,
  input  logic [NUM_ACCUMS*FREQ_BIN_WIDTH-1:0]   freq_bin_i,
  input  logic [THRESH_WIDTH-1:0]                threshold_db_i,
  output logic [FREQ_BIN_WIDTH-1:0]              left_f1_o,
  output logic [FREQ_BIN_WIDTH-1:0]              left_f2_o,
  output logic [ACCUM_WIDTH-1:0]                 left_L1_o,
  output logic [ACCUM_WIDTH-1:0]                 left_L2_o,
  output logic [FREQ_BIN_WIDTH-1:0]              right_f1_o,
  output logic [FREQ_BIN_WIDTH-1:0]              right_f2_o,
  output logic [ACCUM_WIDTH-1:0]                 right_L1_o,
  output logic [ACCUM_WIDTH-1:0]                 right_L2_o,
  output logic [$clog2(NUM_ACCUMS)-1:0]          peak_idx_o,
  output logic [ACCUM_WIDTH-1:0]                 peak_val_o,
  output logic                                   left_found_o,
  output logic                                   right_found_o,
  output logic                                   valid_o,
`ifdef FIND_BW_BANDWIDTH_EN
  output logic [FREQ_BIN_WIDTH-1:0]              bw_o,
`endif
  output logic                                   busy_o
);

  localparam int unsigned AW = ACCUM_WIDTH;
  localparam int unsigned FW = FREQ_BIN_WIDTH;
  localparam int unsigned N  = NUM_ACCUMS;
  localparam int unsigned TW = THRESH_WIDTH;
  localparam int unsigned IW = $clog2(NUM_ACCUMS);
  localparam int unsigned LW = AW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  // The shared bracket record is sized by the package widths.
  if (AW != FB_ACC_W || FW != FB_FREQ_W || TW < Q_FRAC_BITS || TW > AW || N < 2) begin : g_bad_cfg
    $error("find_bw_edges: unsupported parameter set");
  end

  logic [AW-1:0] in_vals  [N];
  logic [FW-1:0] in_freqs [N];
  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign in_vals[g]  = accumulator_val_i[g*AW +: AW];
    assign in_freqs[g] = freq_bin_i[g*FW +: FW];
  end

  state_e            state_q, state_d;
  logic [AW-1:0]     vals_q  [N];
  logic [AW-1:0]     vals_d  [N];
  logic [FW-1:0]     freqs_q [N];
  logic [FW-1:0]     freqs_d [N];
  logic [TW-1:0]     thr_q, thr_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  edge_result_t      left_q, left_d, right_q, right_d;
  edge_result_t      left_out_q, left_out_d, right_out_q, right_out_d;
  logic [IW-1:0]     pidx_out_q, pidx_out_d;
  logic [AW-1:0]     pval_out_q, pval_out_d;
  logic              valid_q, valid_d, busy_q, busy_d;
`ifdef FIND_BW_BANDWIDTH_EN
  logic [FW-1:0]     bw_q, bw_d;
`endif

  logic              ps_start_c, ps_done_c;
  logic [IW-1:0]     ps_idx;
  logic [AW-1:0]     ps_val;
  logic signed [LW-1:0] level_c;
  logic [IW-1:0]     li_c, li_up_c, ri_c, ri_dn_c;

  find_bw_peak_search #(
    .ACCUM_WIDTH (AW),
    .NUM_ACCUMS  (N)
  ) u_peak (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (ps_start_c),
    .vals_i     (vals_q),
    .peak_idx_o (ps_idx),
    .peak_val_o (ps_val),
    .done_c     (ps_done_c)
  );

  // One extra bit so a deep threshold below a low peak cannot wrap.
  assign level_c = $signed({ps_val[AW-1], ps_val}) - $signed({{(LW-TW){1'b0}}, thr_q});
  assign li_c    = ps_idx - cnt_q - IW'(1);
  assign li_up_c = li_c + IW'(1);
  assign ri_c    = ps_idx + cnt_q + IW'(1);
  assign ri_dn_c = ri_c - IW'(1);

  function automatic logic below(input logic [AW-1:0] v, input logic signed [LW-1:0] lvl);
    return $signed({v[AW-1], v}) < lvl;
  endfunction

  function automatic edge_result_t mk_res(input logic [FW-1:0] f1, input logic [FW-1:0] f2,
                                          input logic [AW-1:0] l1, input logic [AW-1:0] l2,
                                          input logic found);
    edge_result_t r;
    r.f1 = f1; r.f2 = f2; r.l1 = l1; r.l2 = l2; r.found = found;
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    vals_d      = vals_q;
    freqs_d     = freqs_q;
    thr_d       = thr_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    right_d     = right_q;
    left_out_d  = left_out_q;
    right_out_d = right_out_q;
    pidx_out_d  = pidx_out_q;
    pval_out_d  = pval_out_q;
    valid_d     = 1'b0;
    ps_start_c  = 1'b0;
`ifdef FIND_BW_BANDWIDTH_EN
    bw_d        = bw_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          ps_start_c = 1'b1;
          vals_d     = in_vals;
          freqs_d    = in_freqs;
          thr_d      = threshold_db_i;
          state_d    = ST_PEAK;
        end
      end
      ST_PEAK: begin
        if (ps_done_c) begin
          cnt_d   = '0;
          state_d = ST_LEFT;
        end
      end
      ST_LEFT: begin
        if (ps_idx == '0) begin
          left_d  = mk_res(freqs_q[0], freqs_q[0], vals_q[0], vals_q[0], 1'b0);
          cnt_d   = '0;
          state_d = ST_RIGHT;
        end else if (below(vals_q[li_c], level_c)) begin
          left_d  = mk_res(freqs_q[li_c], freqs_q[li_up_c], vals_q[li_c], vals_q[li_up_c], 1'b1);
          cnt_d   = '0;
          state_d = ST_RIGHT;
        end else if (li_c == '0) begin
          left_d  = mk_res(freqs_q[0], freqs_q[0], vals_q[0], vals_q[0], 1'b0);
          cnt_d   = '0;
          state_d = ST_RIGHT;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      ST_RIGHT: begin
        if (ps_idx == LAST_IDX) begin
          right_d = mk_res(freqs_q[LAST_IDX], freqs_q[LAST_IDX], vals_q[LAST_IDX], vals_q[LAST_IDX], 1'b0);
          state_d = ST_DONE;
        end else if (below(vals_q[ri_c], level_c)) begin
          right_d = mk_res(freqs_q[ri_dn_c], freqs_q[ri_c], vals_q[ri_dn_c], vals_q[ri_c], 1'b1);
          state_d = ST_DONE;
        end else if (ri_c == LAST_IDX) begin
          right_d = mk_res(freqs_q[LAST_IDX], freqs_q[LAST_IDX], vals_q[LAST_IDX], vals_q[LAST_IDX], 1'b0);
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      ST_DONE: begin
        left_out_d  = left_q;
        right_out_d = right_q;
        pidx_out_d  = ps_idx;
        pval_out_d  = ps_val;
        valid_d     = 1'b1;
`ifdef FIND_BW_BANDWIDTH_EN
        bw_d        = (right_q.f2 >= left_q.f1) ? (right_q.f2 - left_q.f1) : '0;
`endif
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      vals_q      <= '{default: '0};
      freqs_q     <= '{default: '0};
      thr_q       <= '0;
      cnt_q       <= '0;
      left_q      <= '0;
      right_q     <= '0;
      left_out_q  <= '0;
      right_out_q <= '0;
      pidx_out_q  <= '0;
      pval_out_q  <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FIND_BW_BANDWIDTH_EN
      bw_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      vals_q      <= vals_d;
      freqs_q     <= freqs_d;
      thr_q       <= thr_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      right_q     <= right_d;
      left_out_q  <= left_out_d;
      right_out_q <= right_out_d;
      pidx_out_q  <= pidx_out_d;
      pval_out_q  <= pval_out_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
`ifdef FIND_BW_BANDWIDTH_EN
      bw_q        <= bw_d;
`endif
    end
  end

  assign left_f1_o     = left_out_q.f1;
  assign left_f2_o     = left_out_q.f2;
  assign left_L1_o     = left_out_q.l1;
  assign left_L2_o     = left_out_q.l2;
  assign left_found_o  = left_out_q.found;
  assign right_f1_o    = right_out_q.f1;
  assign right_f2_o    = right_out_q.f2;
  assign right_L1_o    = right_out_q.l1;
  assign right_L2_o    = right_out_q.l2;
  assign right_found_o = right_out_q.found;
  assign peak_idx_o    = pidx_out_q;
  assign peak_val_o    = pval_out_q;
  assign valid_o       = valid_q;
  assign busy_o        = busy_q;
`ifdef FIND_BW_BANDWIDTH_EN
  assign bw_o          = bw_q;
`endif

endmodule

// File: tb/tb_find_bw_edges.sv
// Scoreboard bench for find_bw_edges: directed scenarios plus randomized
// snapshots checked against a loop-based reference model.
module tb_find_bw_edges;

  localparam int AW = 18;
  localparam int FW = 16;
  localparam int N  = 24;
  localparam int TW = 16;
  localparam int IW = $clog2(N);

  logic                clk = 1'b0;
  logic                rst_i;
  logic                start_i;
  logic [N*AW-1:0]     accumulator_val_i;
  logic [N*FW-1:0]     freq_bin_i;
  logic [TW-1:0]       threshold_db_i;
  logic [FW-1:0]       left_f1_o, left_f2_o, right_f1_o, right_f2_o;
  logic [AW-1:0]       left_L1_o, left_L2_o, right_L1_o, right_L2_o, peak_val_o;
  logic [IW-1:0]       peak_idx_o;
  logic                left_found_o, right_found_o, valid_o, busy_o;
`ifdef FIND_BW_BANDWIDTH_EN
  logic [FW-1:0]       bw_o;
`endif

  find_bw_edges dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .start_i           (start_i),
    .accumulator_val_i (accumulator_val_i),
    .freq_bin_i        (freq_bin_i),
    .threshold_db_i    (threshold_db_i),
    .left_f1_o         (left_f1_o),
    .left_f2_o         (left_f2_o),
    .left_L1_o         (left_L1_o),
    .left_L2_o         (left_L2_o),
    .right_f1_o        (right_f1_o),
    .right_f2_o        (right_f2_o),
    .right_L1_o        (right_L1_o),
    .right_L2_o        (right_L2_o),
    .peak_idx_o        (peak_idx_o),
    .peak_val_o        (peak_val_o),
    .left_found_o      (left_found_o),
    .right_found_o     (right_found_o),
    .valid_o           (valid_o),
`ifdef FIND_BW_BANDWIDTH_EN
    .bw_o              (bw_o),
`endif
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pidx, pval;
    int lf1, lf2, ll1, ll2, lfound;
    int rf1, rf2, rl1, rl2, rfound;
    int bw, lat, start;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   cur_v [N];
  int   cur_f [N];
  int   cur_thr;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Reference: argmax with first-wins ties, then outward linear scans for the first bin below level.
  function automatic exp_t model(input int v[N], input int f[N], input int thr);
    exp_t e;
    int pk = 0;
    int lvl, lc, rc;
    for (int i = 1; i < N; i++) if (v[i] > v[pk]) pk = i;
    lvl = v[pk] - thr;
    e.pidx = pk; e.pval = v[pk];
    e.lfound = 0; e.lf1 = f[0]; e.lf2 = f[0]; e.ll1 = v[0]; e.ll2 = v[0];
    lc = (pk == 0) ? 1 : pk;
    for (int i = pk - 1; i >= 0; i--) begin
      if (e.lfound == 0 && v[i] < lvl) begin
        e.lfound = 1; e.lf1 = f[i]; e.lf2 = f[i+1]; e.ll1 = v[i]; e.ll2 = v[i+1];
        lc = pk - i;
      end
    end
    e.rfound = 0; e.rf1 = f[N-1]; e.rf2 = f[N-1]; e.rl1 = v[N-1]; e.rl2 = v[N-1];
    rc = (pk == N - 1) ? 1 : N - 1 - pk;
    for (int j = pk + 1; j < N; j++) begin
      if (e.rfound == 0 && v[j] < lvl) begin
        e.rfound = 1; e.rf1 = f[j-1]; e.rf2 = f[j]; e.rl1 = v[j-1]; e.rl2 = v[j];
        rc = j - pk;
      end
    end
    e.bw    = (e.rf2 >= e.lf1) ? e.rf2 - e.lf1 : 0;
    e.lat   = N + lc + rc + 1;
    e.start = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("latency",     cyc - e.start,               e.lat);
        chk("busy_at_valid", int'(busy_o),              0);
        chk("peak_idx",    int'(peak_idx_o),            e.pidx);
        chk("peak_val",    int'($signed(peak_val_o)),   e.pval);
        chk("left_found",  int'(left_found_o),          e.lfound);
        chk("left_f1",     int'(left_f1_o),             e.lf1);
        chk("left_f2",     int'(left_f2_o),             e.lf2);
        chk("left_L1",     int'($signed(left_L1_o)),    e.ll1);
        chk("left_L2",     int'($signed(left_L2_o)),    e.ll2);
        chk("right_found", int'(right_found_o),         e.rfound);
        chk("right_f1",    int'(right_f1_o),            e.rf1);
        chk("right_f2",    int'(right_f2_o),            e.rf2);
        chk("right_L1",    int'($signed(right_L1_o)),   e.rl1);
        chk("right_L2",    int'($signed(right_L2_o)),   e.rl2);
`ifdef FIND_BW_BANDWIDTH_EN
        chk("bw",          int'(bw_o),                  e.bw);
`endif
      end
    end
  end

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      accumulator_val_i[i*AW +: AW] = AW'(cur_v[i]);
      freq_bin_i[i*FW +: FW]        = FW'(cur_f[i]);
    end
    threshold_db_i = TW'(cur_thr);
  endtask

  task automatic scramble_bus();
    for (int i = 0; i < N; i++) begin
      accumulator_val_i[i*AW +: AW] = AW'($urandom);
      freq_bin_i[i*FW +: FW]        = FW'($urandom);
    end
    threshold_db_i = TW'($urandom);
  endtask

  task automatic issue();
    exp_t e;
    @(negedge clk);
    drive_bus();
    start_i = 1'b1;
    e = model(cur_v, cur_f, cur_thr);
    e.start = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    start_i = 1'b0;
    scramble_bus();
    chk("busy_after_start", int'(busy_o), 1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("completion_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic set_base(input int v);
    for (int i = 0; i < N; i++) begin
      cur_v[i] = v;
      cur_f[i] = i * 256;
    end
    cur_thr = 7680;
  endtask

  task automatic set_scn1();
    set_base(-10240);
    for (int i = 10; i <= 14; i++) cur_v[i] = -2560;
    cur_v[12] = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_left_f1"},   int'(left_f1_o),     0);
    chk({tag, "_left_f2"},   int'(left_f2_o),     0);
    chk({tag, "_left_L1"},   int'(left_L1_o),     0);
    chk({tag, "_left_L2"},   int'(left_L2_o),     0);
    chk({tag, "_right_f1"},  int'(right_f1_o),    0);
    chk({tag, "_right_f2"},  int'(right_f2_o),    0);
    chk({tag, "_right_L1"},  int'(right_L1_o),    0);
    chk({tag, "_right_L2"},  int'(right_L2_o),    0);
    chk({tag, "_peak_idx"},  int'(peak_idx_o),    0);
    chk({tag, "_peak_val"},  int'(peak_val_o),    0);
    chk({tag, "_found"},     int'({left_found_o, right_found_o}), 0);
    chk({tag, "_valid"},     int'(valid_o),       0);
    chk({tag, "_busy"},      int'(busy_o),        0);
`ifdef FIND_BW_BANDWIDTH_EN
    chk({tag, "_bw"},        int'(bw_o),          0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st;
    rst_i = 1'b1;
    start_i = 1'b0;
    accumulator_val_i = '0;
    freq_bin_i = '0;
    threshold_db_i = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_i = 1'b0;

    // Scenario 1: plateau around bin 12, 30 dB down.
    set_scn1();
    issue(); wait_done();

    // Scenario 2: peak at bin 0.
    set_base(-10240);
    cur_v[0] = 0;
    issue(); wait_done();

    // Scenario 3: flat spectrum, no crossings either side.
    set_base(-5000);
    issue(); wait_done();

    // Scenario 4: zero threshold needs strictly-below.
    set_base(-10240);
    cur_v[11] = -256; cur_v[12] = 0; cur_v[13] = -256;
    cur_thr = 0;
    issue(); wait_done();

    // Peak at the last bin.
    set_base(-10240);
    cur_v[N-1] = 512; cur_v[N-2] = -1000;
    issue(); wait_done();

    // Start mid-PEAK with different data must be ignored.
    set_scn1();
    issue();
    repeat (5) @(negedge clk);
    set_base(-5000);
    cur_v[3] = 100;
    drive_bus();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done();

    // Reset during LEFT aborts with no valid and clears outputs.
    set_scn1();
    issue();
    st = exp_q[0].start;
    while (cyc < st + 25) @(negedge clk);
    rst_i = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_zero("abort");
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    repeat (60) @(negedge clk);

    // Randomized snapshots: full range, tie-heavy, and peaked shapes.
    for (int r = 0; r < 45; r++) begin
      int mode, pk;
      mode = r % 3;
      for (int i = 0; i < N; i++) cur_f[i] = i * 256;
      if (mode == 0) begin
        for (int i = 0; i < N; i++) begin
          cur_v[i] = int'($urandom_range(0, 262143)) - 131072;
          cur_f[i] = int'($urandom_range(0, 65535));
        end
        cur_thr = int'($urandom_range(0, 65535));
      end else if (mode == 1) begin
        for (int i = 0; i < N; i++) cur_v[i] = (int'($urandom_range(0, 6)) - 3) * 256;
        cur_thr = int'($urandom_range(0, 1024));
      end else begin
        pk = int'($urandom_range(0, N - 1));
        for (int i = 0; i < N; i++)
          cur_v[i] = -((i > pk) ? i - pk : pk - i) * int'($urandom_range(200, 3000));
        cur_thr = int'($urandom_range(0, 20000));
      end
      issue(); wait_done();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
